// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX write-port arbiter.
package uart_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the TX FIFO write port, bundled for the arbiter.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = UART_DATA_BITS
);
   logic [NUM_REQ-1:0]           i_req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] i_req_data;
   logic [NUM_REQ-1:0]           i_req_last;
   logic [NUM_REQ-1:0]           o_req_ready;
   logic                         o_fifo_wr_en;
   logic [DATA_BITS-1:0]         o_fifo_data;
   logic                         i_fifo_full;
   logic [NUM_REQ-1:0]           o_grant;
   logic                         o_busy;

   // Requesters and the FIFO side of the world.
   modport master (
      output i_req_valid, i_req_data, i_req_last, i_fifo_full,
      input  o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
      output o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_busy
   );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1 with wrap.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PTR_W-1:0]   grant_idx_o,
   output logic               any_req_o
);

   logic found;
   int   idx;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      any_req_o   = |req_i;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX FIFO write port; a grant is held for a whole message or MAX_BURST bytes.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   uart_tx_arbiter_if.slave  bus
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

   arb_state_t           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_REQ-1:0]   pick_grant;
   logic [PTR_W-1:0]     pick_idx;
   logic                 pick_any;

   logic                 owner_valid;
   logic                 owner_last;
   logic [DATA_BITS-1:0] owner_data;
   logic                 xfer;
   logic                 burst_done;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req_i       (bus.i_req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (pick_grant),
      .grant_idx_o (pick_idx),
      .any_req_o   (pick_any)
   );

   always_comb begin
      owner_valid = bus.i_req_valid[owner_q];
      owner_last  = bus.i_req_last[owner_q];
      owner_data  = bus.i_req_data[int'(owner_q)*DATA_BITS +: DATA_BITS];
   end

   assign xfer       = (state_q == ARB_LOCKED) && owner_valid && !bus.i_fifo_full;
   // Counter holds the number of bytes already moved, so the MAX_BURST-th transfer sees MAX_BURST-1.
   assign burst_done = (MAX_BURST != 0) && (cnt_q == CNT_W'(MAX_BURST - 1));

   assign bus.o_fifo_wr_en = xfer;
   assign bus.o_fifo_data  = xfer ? owner_data : '0;
   assign bus.o_req_ready  = ((state_q == ARB_LOCKED) && !bus.i_fifo_full) ? grant_q : '0;
   assign bus.o_grant      = grant_q;
   assign bus.o_busy       = (state_q == ARB_LOCKED);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_LOCKED;
               grant_d = pick_grant;
               owner_d = pick_idx;
               cnt_d   = '0;
            end
         end
         ARB_LOCKED: begin
            if (xfer) begin
               if (owner_last || burst_done) begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
                  ptr_d   = owner_q;
                  cnt_d   = '0;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Pointer starts at the last index so requester 0 wins the first arbitration.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-based requesters, a per-cycle reference model and literal checks.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DB = 8;
   localparam int MB = 16;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ   (NR),
      .DATA_BITS (DB),
      .MAX_BURST (MB)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Requester byte queues: bit 8 marks the last byte of a message.
   logic [8:0]    mem [NR][128];
   int            head [NR] = '{default: 0};
   int            tail [NR] = '{default: 0};
   logic          hold [NR] = '{default: 1'b0};
   logic [NR-1:0] acc = '0;
   logic          full_ctl = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: owner index (-1 when idle), last-served pointer, bytes moved this grant.
   int m_owner = -1;
   int m_ptr   = NR - 1;
   int m_cnt   = 0;

   logic [7:0]    push_data [64];
   int            push_cyc  [64];
   int            n_push = 0;
   int            first_valid_cyc = -1;
   int            first_grant_cyc = -1;
   logic [NR-1:0] first_grant_val = '0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic load(input int r, input logic [7:0] d, input logic last);
      mem[r][tail[r]] = {last, d};
      tail[r]++;
   endtask

   task automatic wait_push(input int n, input int budget, input string name);
      int b = 0;
      while (n_push < n && b < budget) begin
         @(posedge clk);
         b++;
      end
      total++;
      if (n_push < n) begin
         bad++;
         $display("FAIL %s timeout pushes=%0d want=%0d", name, n_push, n);
      end
   endtask

   task automatic clear_logs();
      n_push          = 0;
      first_valid_cyc = -1;
      first_grant_cyc = -1;
      first_grant_val = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 n_rst = 1'b0;
      #2;
      for (int r = 0; r < NR; r++) begin
         head[r] = 0;
         tail[r] = 0;
         hold[r] = 1'b0;
      end
      full_ctl = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      clear_logs();
   endtask

   // Requester / FIFO driver: retire accepted bytes, present the next ones.
   initial begin
      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      bus.i_req_last  = '0;
      bus.i_fifo_full = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         for (int r = 0; r < NR; r++) begin
            if (acc[r]) head[r]++;
         end
         acc = '0;
         for (int r = 0; r < NR; r++) begin
            bus.i_req_valid[r]         = (head[r] < tail[r]) && !hold[r];
            bus.i_req_data[r*DB +: DB] = (head[r] < tail[r]) ? mem[r][head[r]][7:0] : 8'h00;
            bus.i_req_last[r]          = (head[r] < tail[r]) ? mem[r][head[r]][8] : 1'b0;
         end
         bus.i_fifo_full = full_ctl;
      end
   end

   // Compare process: check every cycle against the model, then advance the model.
   initial begin
      logic [NR-1:0] eg, er;
      logic          eb, ew;
      logic [7:0]    ed;
      bit            found;
      forever begin
         @(negedge clk);
         cyc++;
         if (!n_rst) begin
            m_owner = -1;
            m_ptr   = NR - 1;
            m_cnt   = 0;
         end
         eg = '0; er = '0; eb = 1'b0; ew = 1'b0; ed = 8'h00;
         if (m_owner >= 0) begin
            eg = NR'(1) << m_owner;
            eb = 1'b1;
            er = bus.i_fifo_full ? '0 : eg;
            ew = bus.i_req_valid[m_owner] && !bus.i_fifo_full;
            ed = ew ? mem[m_owner][head[m_owner]][7:0] : 8'h00;
         end
         total++;
         if ({bus.o_grant, bus.o_busy, bus.o_req_ready, bus.o_fifo_wr_en, bus.o_fifo_data} !==
             {eg, eb, er, ew, ed}) begin
            bad++;
            $display("FAIL cycle_model cyc=%0d got grant=%b busy=%b ready=%b wr=%b data=%h want grant=%b busy=%b ready=%b wr=%b data=%h",
                     cyc, bus.o_grant, bus.o_busy, bus.o_req_ready, bus.o_fifo_wr_en, bus.o_fifo_data,
                     eg, eb, er, ew, ed);
         end
         if (bus.o_fifo_wr_en === 1'b1) begin
            if (n_push < 64) begin
               push_data[n_push] = bus.o_fifo_data;
               push_cyc[n_push]  = cyc;
            end
            $display("push cyc=%0d data=%h grant=%b", cyc, bus.o_fifo_data, bus.o_grant);
            n_push++;
         end
         if (n_rst && first_valid_cyc < 0 && |bus.i_req_valid) first_valid_cyc = cyc;
         if (n_rst && first_grant_cyc < 0 && |bus.o_grant) begin
            first_grant_cyc = cyc;
            first_grant_val = bus.o_grant;
         end
         acc = n_rst ? (bus.i_req_valid & bus.o_req_ready) : '0;
         if (n_rst) begin
            if (m_owner < 0) begin
               found = 1'b0;
               for (int k = 1; k <= NR; k++) begin
                  if (!found && bus.i_req_valid[(m_ptr + k) % NR]) begin
                     found   = 1'b1;
                     m_owner = (m_ptr + k) % NR;
                     m_cnt   = 0;
                  end
               end
            end else if (ew) begin
               m_cnt++;
               if (mem[m_owner][head[m_owner]][8] || (MB != 0 && m_cnt == MB)) begin
                  m_ptr   = m_owner;
                  m_owner = -1;
                  m_cnt   = 0;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant", bus.o_grant, 0);
      chk("reset_busy", bus.o_busy, 0);
      chk("reset_ready", bus.o_req_ready, 0);
      chk("reset_wr_en", bus.o_fifo_wr_en, 0);

      // 1: req1 sends a 3-byte message.
      do_reset();
      load(1, 8'h41, 1'b0);
      load(1, 8'h42, 1'b0);
      load(1, 8'h43, 1'b1);
      wait_push(3, 50, "t1_wait");
      repeat (3) @(posedge clk);
      #1;
      chk("t1_grant_val", first_grant_val, 'b0010);
      chk("t1_grant_latency", first_grant_cyc - first_valid_cyc, 1);
      chk("t1_first_push_cyc", push_cyc[0] - first_grant_cyc, 0);
      chk("t1_push0", push_data[0], 'h41);
      chk("t1_push1", push_data[1], 'h42);
      chk("t1_push2", push_data[2], 'h43);
      chk("t1_consecutive", push_cyc[2] - push_cyc[0], 2);
      chk("t1_idle_busy", bus.o_busy, 0);
      chk("t1_push_count", n_push, 3);

      // 2: all four requesters with single-byte messages, req0 twice.
      do_reset();
      load(0, 8'h00, 1'b1);
      load(1, 8'h10, 1'b1);
      load(2, 8'h20, 1'b1);
      load(3, 8'h30, 1'b1);
      load(0, 8'h01, 1'b1);
      wait_push(5, 100, "t2_wait");
      chk("t2_order0", push_data[0], 'h00);
      chk("t2_order1", push_data[1], 'h10);
      chk("t2_order2", push_data[2], 'h20);
      chk("t2_order3", push_data[3], 'h30);
      chk("t2_order4", push_data[4], 'h01);
      for (int i = 1; i < 5; i++) chk($sformatf("t2_gap%0d", i), push_cyc[i] - push_cyc[i-1], 2);

      // 3: req0 streams 40 bytes without last while req2 has a 3-byte message.
      do_reset();
      for (int i = 0; i < 40; i++) load(0, 8'(i), 1'b0);
      load(2, 8'hA0, 1'b0);
      load(2, 8'hA1, 1'b0);
      load(2, 8'hA2, 1'b1);
      wait_push(40, 200, "t3_wait");
      #1;
      chk("t3_burst_end", push_data[15], 15);
      chk("t3_req2_first", push_data[16], 'hA0);
      chk("t3_req2_last", push_data[18], 'hA2);
      chk("t3_req0_resume", push_data[19], 16);
      chk("t3_second_burst_end", push_data[34], 31);
      chk("t3_third_burst", push_data[35], 32);
      chk("t3_switch_gap", push_cyc[16] - push_cyc[15], 2);
      chk("t3_regrant_gap", push_cyc[35] - push_cyc[34], 2);
      chk("t3_still_locked", bus.o_busy, 1);

      // 4: FIFO full for 5 cycles mid-message.
      do_reset();
      for (int i = 0; i < 10; i++) load(1, 8'(8'h50 + i), i == 9);
      wait_push(3, 50, "t4_wait_a");
      #1 full_ctl = 1'b1;
      repeat (5) @(posedge clk);
      #1 full_ctl = 1'b0;
      wait_push(10, 100, "t4_wait_b");
      repeat (2) @(posedge clk);
      for (int i = 0; i < 10; i++) chk($sformatf("t4_push%0d", i), push_data[i], 'h50 + i);
      chk("t4_stall_gap", push_cyc[3] - push_cyc[2], 6);
      chk("t4_push_count", n_push, 10);

      // 5: owner drops valid for 10 cycles while req3 waits.
      do_reset();
      for (int i = 0; i < 8; i++) load(0, 8'(8'h60 + i), i == 7);
      load(3, 8'h70, 1'b0);
      load(3, 8'h71, 1'b1);
      wait_push(3, 50, "t5_wait_a");
      #1 hold[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1 hold[0] = 1'b0;
      wait_push(10, 100, "t5_wait_b");
      for (int i = 0; i < 8; i++) chk($sformatf("t5_push%0d", i), push_data[i], 'h60 + i);
      chk("t5_req3_a", push_data[8], 'h70);
      chk("t5_req3_b", push_data[9], 'h71);
      chk("t5_hold_gap", push_cyc[3] - push_cyc[2], 11);

      // 6: reset pulse after 2 of 5 bytes; req0 must win again afterwards.
      do_reset();
      for (int i = 0; i < 5; i++) load(0, 8'(8'h90 + i), i == 4);
      load(1, 8'h11, 1'b1);
      wait_push(2, 50, "t6_wait_a");
      #1 n_rst = 1'b0;
      #1;
      chk("t6_async_grant", bus.o_grant, 0);
      chk("t6_async_busy", bus.o_busy, 0);
      chk("t6_async_ready", bus.o_req_ready, 0);
      chk("t6_async_wr_en", bus.o_fifo_wr_en, 0);
      for (int r = 0; r < NR; r++) begin
         head[r] = 0;
         tail[r] = 0;
      end
      chk("t6_pre_reset_pushes", n_push, 2);
      repeat (2) @(posedge clk);
      #1;
      load(0, 8'h95, 1'b1);
      load(1, 8'h11, 1'b1);
      n_rst = 1'b1;
      wait_push(4, 50, "t6_wait_b");
      chk("t6_after_reset_first", push_data[2], 'h95);
      chk("t6_after_reset_second", push_data[3], 'h11);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
